// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_if
// Description : Request/response bundle for the execute-stage ALU. The master
//               side issues operations and accepts results; the slave side is
//               the ALU itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_control_lines;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   modport master (
      output in_valid, alu_control_lines, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, alu_control_lines, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU with valid/ready handshake. Logic and
//               arithmetic ops finish in one cycle; shifts iterate one bit per
//               cycle so no barrel shifter is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  wire logic clk,
   input  wire logic reset,
   alu_exec_if.slave bus
);

   localparam logic [3:0] c_OP_AND = 4'b0000;
   localparam logic [3:0] c_OP_OR  = 4'b0001;
   localparam logic [3:0] c_OP_ADD = 4'b0010;
   localparam logic [3:0] c_OP_XOR = 4'b0011;
   localparam logic [3:0] c_OP_SLL = 4'b0100;
   localparam logic [3:0] c_OP_SRA = 4'b0101;
   localparam logic [3:0] c_OP_SUB = 4'b0110;
   localparam logic [3:0] c_OP_SRL = 4'b0111;

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   logic [1:0]         r_state;
   logic [XLEN-1:0]    r_result;
   logic               r_zero;
   logic               r_illegal;
   logic [SHAMT_W-1:0] r_cnt;
   logic [3:0]         r_shop;

   logic               w_accept;
   logic [XLEN-1:0]    w_op_val;
   logic               w_op_illegal;
   logic               w_is_shift;
   logic [SHAMT_W-1:0] w_shamt;
   logic [XLEN-1:0]    w_shift_next;

   assign w_accept = bus.in_valid && (r_state == c_IDLE);
   assign w_shamt  = bus.operand_b[SHAMT_W-1:0];

   // Decode the incoming operation into its single-cycle value and class
   always_comb begin
      w_op_val     = '0;
      w_op_illegal = 1'b0;
      w_is_shift   = 1'b0;
      case (bus.alu_control_lines)
         c_OP_AND: w_op_val = bus.operand_a & bus.operand_b;
         c_OP_OR:  w_op_val = bus.operand_a | bus.operand_b;
         c_OP_ADD: w_op_val = bus.operand_a + bus.operand_b;
         c_OP_XOR: w_op_val = bus.operand_a ^ bus.operand_b;
         c_OP_SUB: w_op_val = bus.operand_a - bus.operand_b;
         c_OP_SLL, c_OP_SRA, c_OP_SRL: begin
            w_op_val   = bus.operand_a;
            w_is_shift = 1'b1;
         end
         default:  w_op_illegal = 1'b1;
      endcase
   end

   // One-bit step of the shift latched at accept time
   always_comb begin
      w_shift_next = r_result;
      case (r_shop)
         c_OP_SLL: w_shift_next = {r_result[XLEN-2:0], 1'b0};
         c_OP_SRL: w_shift_next = {1'b0, r_result[XLEN-1:1]};
         c_OP_SRA: w_shift_next = {r_result[XLEN-1], r_result[XLEN-1:1]};
         default:  w_shift_next = r_result;
      endcase
   end

   // Control FSM plus result/flag/counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
         r_shop    <= c_OP_AND;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_result  <= w_op_val;
                  r_zero    <= (w_op_val == '0);
                  r_illegal <= w_op_illegal;
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_cnt   <= w_shamt;
                     r_shop  <= bus.alu_control_lines;
                     r_state <= c_SHIFT;
                  end else begin
                     r_state <= c_DONE;
                  end
               end
            end
            c_SHIFT: begin
               r_result <= w_shift_next;
               r_cnt    <= r_cnt - 1'b1;
               // zero must reflect the final value on the cycle DONE is entered
               if (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                  r_zero  <= (w_shift_next == '0);
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               if (bus.out_ready) begin
                  r_state <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == c_IDLE);
   assign bus.out_valid = (r_state == c_DONE);
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   localparam int c_XLEN = 32;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   alu_exec_if #(.XLEN(c_XLEN)) bus ();

   alu_exec_unit #(.XLEN(c_XLEN), .SHAMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for out_valid, then check latency, result and flags
   task automatic run_op(input string tag, input logic [3:0] code,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_zero,
                         input logic exp_ill, input int exp_lat, input logic noise);
      int   lat;
      logic ready_bad;
      bus.in_valid          = 1'b1;
      bus.alu_control_lines = code;
      bus.operand_a         = a;
      bus.operand_b         = b;
      step();
      // Scramble inputs after capture; the op in flight must not notice
      bus.in_valid          = noise;
      bus.alu_control_lines = 4'b0010;
      bus.operand_a         = 32'hDEAD_BEEF;
      bus.operand_b         = 32'h1234_5678;
      lat       = 1;
      ready_bad = 1'b0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) ready_bad = 1'b1;
         step();
         lat++;
      end
      bus.in_valid = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, bus.result, exp_res);
      check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
      check({tag, "_illegal"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
      check({tag, "_busy_ready"}, {31'd0, ready_bad}, 32'd0);
   endtask

   // Complete the output handshake and check the unit returns to IDLE
   task automatic finish_op(input string tag);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_ovalid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_iready_back"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.in_valid          = 1'b0;
      bus.alu_control_lines = 4'b0000;
      bus.operand_a         = '0;
      bus.operand_b         = '0;
      bus.out_ready         = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_result", bus.result, 32'h0);
      check("rst_zero", {31'd0, bus.zero}, 32'd1);
      check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
      check("rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_iready", {31'd0, bus.in_ready}, 32'd1);

      // ADD wraps into the sign bit, SUB to zero
      run_op("add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b0);
      finish_op("add");
      run_op("sub", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1, 1'b0);
      finish_op("sub");
      run_op("or", 4'b0001, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1'b0, 1'b0, 1, 1'b0);
      finish_op("or");
      run_op("xor", 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1, 1'b0);
      finish_op("xor");

      // Long arithmetic shift with in_valid held high as noise throughout
      run_op("sra31", 4'b0101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 1'b1);
      finish_op("sra31");

      // Shift corner cases: shamt=0 ignoring upper b bits, and a short SRL
      run_op("sll0", 4'b0100, 32'h1, 32'hFFFF_FFE0, 32'h1, 1'b0, 1'b0, 1, 1'b0);
      finish_op("sll0");
      run_op("srl4", 4'b0111, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5, 1'b0);
      finish_op("srl4");
      run_op("sll_out", 4'b0100, 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b0, 1'b0, 2, 1'b0);
      finish_op("sll_out");
      run_op("srl_zero", 4'b0111, 32'h0000_0001, 32'd1, 32'h0, 1'b1, 1'b0, 2, 1'b0);
      finish_op("srl_zero");

      // Backpressure: output held stable for 10 cycles while in_valid pulses
      run_op("bp", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid          = i[0];
         bus.alu_control_lines = 4'b0110;
         bus.operand_a         = 32'd100;
         bus.operand_b         = 32'd1;
         step();
         check("bp_hold", {bus.out_valid, bus.zero, bus.illegal, bus.in_ready, bus.result[27:0]},
               {1'b1, 1'b0, 1'b0, 1'b0, 28'd7});
      end
      bus.in_valid = 1'b0;
      finish_op("bp");

      // Illegal code followed by a legal AND clearing the flag
      run_op("ill", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b1, 1, 1'b0);
      finish_op("ill");
      run_op("and", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1, 1'b0);
      finish_op("and");

      // Reset mid-SHIFT drops the op in flight
      bus.in_valid          = 1'b1;
      bus.alu_control_lines = 4'b0100;
      bus.operand_a         = 32'h1;
      bus.operand_b         = 32'd20;
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.out_ready = 1'b0;
      check("mrst_iready", {31'd0, bus.in_ready}, 32'd1);
      check("mrst_ovalid", {31'd0, bus.out_valid}, 32'd0);
      check("mrst_result", bus.result, 32'h0);
      check("mrst_zero", {31'd0, bus.zero}, 32'd1);
      begin
         logic stale;
         stale = 1'b0;
         for (int i = 0; i < 25; i++) begin
            step();
            if (bus.out_valid) stale = 1'b1;
         end
         check("mrst_no_stale", {31'd0, stale}, 32'd0);
      end
      run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b0);
      finish_op("post_rst_add");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU with a valid/ready handshake. It consumes the 4-bit alu_control_lines code from the ALU control decoder plus two operands, and returns a registered result and zero flag.
- Logic, arithmetic and code-error operations complete in 1 cycle. Shifts run iteratively, one bit per cycle, which avoids a barrel shifter on the single-cycle core's area budget.
- Sits between the ALU control decoder/register-file read and the writeback/branch-resolve logic.

Parameters:
- XLEN, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width (log2 XLEN); shamt = operand_b[SHAMT_W-1:0]

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept an operation
- alu_control_lines  input  4  operation code
- operand_a  input  XLEN  first operand / shift source
- operand_b  input  XLEN  second operand / shift amount source
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  result == 0
- illegal  output  1  operation code was not recognised

Behaviour:
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRA, 0110 SUB, 0111 SRL.
  - Any other code (including 1111) is illegal.
- ADD/SUB wrap modulo 2^XLEN. No overflow or carry output.
- State machine states are IDLE, SHIFT and DONE. Reset state is IDLE.
- Reset values: result=0, zero=1, illegal=0, out_valid=0. Internal shift counter = 0.
- in_ready = (state==IDLE), combinational from state only.
- Accept occurs when in_valid && in_ready. Inputs are captured on that edge and need not be held afterwards.
- IDLE, on accept:
  - Non-shift code: result loads the op value; illegal code: result=0, illegal=1. Go to DONE. Latency is 1 cycle: out_valid is high the cycle after accept.
  - Shift code with shamt==0: result=operand_a, go to DONE (latency 1).
  - Shift code with shamt!=0: result=operand_a, counter=shamt, latch the shift kind, go to SHIFT.
- SHIFT, one bit per cycle:
  - SLL: result<<1, zero-fill.
  - SRL: result>>1, zero-fill.
  - SRA: result>>1, replicating the MSB.
  - Counter decrements each cycle. When it reaches 0, go to DONE.
  - Total latency from accept to out_valid = shamt+1 cycles, e.g. shamt=31 gives 32 cycles.
- DONE:
  - out_valid=1, result/zero/illegal are held stable.
  - On out_ready: go to IDLE and out_valid drops the next cycle.
  - No new accept is possible in the cycle of the output handshake. Back-to-back throughput is one op per 2 cycles minimum.
- zero is recomputed from the final result when entering DONE. Its value outside DONE is don't-care but must equal (result==0) whenever out_valid=1.
- illegal is cleared on every new accept and set only for illegal codes.
- in_valid in SHIFT/DONE is ignored, with no capture. Input changes during SHIFT do not affect the op in flight.
- out_ready high while not in DONE has no effect.
- Reset asserted in any state, including mid-SHIFT or DONE with out_ready low:
  - Next cycle state=IDLE and all outputs take reset values.
  - The in-flight op is dropped and no out_valid is produced for it.
- Reset has priority over simultaneous in_valid or out_ready.

Test Plan:
- ADD and SUB: code 0010, a=0x7FFFFFFF, b=1 -> out_valid 1 cycle after accept, result=0x80000000, zero=0. Code 0110, a=5, b=5 -> result=0, zero=1.
- SRA: code 0101, a=0x80000000, b=0x0000001F -> out_valid exactly 32 cycles after accept, result=0xFFFFFFFF. in_ready=0 throughout.
- Shift corner cases:
  - Code 0100, a=0x1, b=0xFFFFFFE0 (shamt=0) -> result=0x1 after 1 cycle.
  - Code 0111, a=0x80000000, b=4 -> result=0x08000000 after 5 cycles.
- Backpressure: ADD completes with out_ready held low 10 cycles -> out_valid, result and zero stable all 10 cycles, in_valid pulses ignored. Raising out_ready -> in_ready=1 the next cycle.
- Illegal code: code 1111, any operands -> result=0, illegal=1, zero=1 after 1 cycle. The following AND 0xF0F0 & 0x0FF0 -> result=0x00F0, illegal=0.
- Reset mid-SHIFT: SLL with shamt=20, reset asserted on cycle 6 -> next cycle in_ready=1, out_valid=0, result=0. No stale result emerges. A new ADD 2+3 -> result=5.
